l2_arbiter_rr: RTL and testbench
================================

// Module: l2_arbiter_rr
// PURPOSE
//  Parametrised N-port round-robin arbiter between the L1 caches and the shared L2.
//  Next generation of the fixed 2-port i/d arbiter.
//  Accepts whole-line read/write requests from NUM_PORTS requesters.
//  Grants one requester at a time and forwards its request to L2 through registered outputs.
//  Returns the registered L2 rdata/resp to the granted port only.
// PARAMETERS
//  NUM_PORTS  2    number of requesters, >=2; port 0 = i-cache, port 1 = d-cache
//  ADDR_W     16   address width (lc3b_word)
//  LINE_W     128  cache line width (lc3b_c_line)
// PORTS
//  clk            in   1                  clock, all state on rising edge
//  reset          in   1                  asynchronous, active-high reset
//  req_address    in   NUM_PORTS*ADDR_W   per-port line address, port p at [p*ADDR_W +: ADDR_W]
//  req_read       in   NUM_PORTS          per-port read request, held until that port's resp
//  req_write      in   NUM_PORTS          per-port write request, held until that port's resp
//  req_wdata      in   NUM_PORTS*LINE_W   per-port write line, port p at [p*LINE_W +: LINE_W]
//  req_rdata      out  LINE_W             registered read line, valid while resp[g]=1
//  req_resp       out  NUM_PORTS          one-hot, 1-cycle completion pulse to granted port
//  L2_mem_address out  ADDR_W             registered address to L2
//  L2_mem_read    out  1                  registered read strobe to L2
//  L2_mem_write   out  1                  registered write strobe to L2
//  L2_mem_wdata   out  LINE_W             registered write line to L2
//  L2_mem_resp    in   1                  L2 completion, 1-cycle pulse
//  L2_mem_rdata   in   LINE_W             L2 read line, valid with L2_mem_resp
// BEHAVIOUR
//  Reset values
//   - All outputs = 0.
//   - FSM = IDLE; grant index g = 0.
//   - Round-robin pointer last = NUM_PORTS-1, so port 0 wins first.
//  Request rules
//   - A port is requesting when req_read[p] | req_write[p].
//   - If both are set on one port, write wins and read is ignored.
//  FSM states
//   - IDLE: if any port is requesting, pick the first requesting port scanning cyclically from last+1.
//     At the edge: latch g, set last=g, load L2_mem_* from port g, go to BUSY. Otherwise stay.
//   - BUSY: hold L2_mem_* constant and ignore all req_* changes.
//     On L2_mem_resp=1 at the edge: capture req_rdata<=L2_mem_rdata, req_resp<=onehot(g), clear L2_mem_read/write, go to RESP.
//   - RESP: req_resp[g]=1 for exactly this cycle. At the edge: clear req_resp, go to IDLE.
//  Latency
//   - Request visible in IDLE at cycle t gives L2 strobe at t+1.
//   - L2_mem_resp at cycle k gives req_resp at k+1.
//   - Minimum request-to-resp latency = L2 latency + 2 cycles.
//  Requester contract
//   - Deassert req_read/req_write in the cycle after req_resp, so the request is not re-granted in IDLE.
//  Fairness
//   - With all ports requesting continuously, grants rotate 0,1,...,N-1,0.
//   - A requesting port waits at most NUM_PORTS-1 transactions.
//  Data and output rules
//   - Address and wdata are captured at grant and are not re-sampled.
//   - req_rdata holds its value until the next L2_mem_resp; it is also updated on writes.
//   - Non-granted ports never see req_resp.
//  Boundary conditions
//   - L2_mem_resp in IDLE or RESP: ignored, no state change.
//   - Port requesting in the same cycle its previous resp completes: treated as a new request, arbitrated normally.
//   - Reset mid-transaction: outputs drop to 0 immediately (asynchronous), the L2 transaction is abandoned,
//     the pointer is re-initialised, and any later stray L2_mem_resp is ignored.
// CONFIGURATION
//  ARB_FIXED_PRIO_EN defined
//   - Fixed priority: lowest-index requesting port always wins; the pointer is unused.
//   - Port 0 (i-cache) can starve higher ports.
//  ARB_FIXED_PRIO_EN undefined (default)
//   - Round-robin as described above.
// TESTING
//  1. Reset, single read: port 1 reads 0x1230; L2 responds 3 cycles later with 0xA5..A5.
//     -> L2_mem_read=1 from t+1, address 0x1230; resp[1] pulses one cycle later;
//        req_rdata=0xA5..A5; resp[0] stays 0.
//  2. Simultaneous: ports 0 and 1 both read, N=2.
//     -> port 0 served first, then port 1; L2_mem_read low for >=1 cycle between transactions.
//  3. Rotation, N=4: all ports request continuously for 8 transactions.
//     -> grant order 0,1,2,3,0,1,2,3.
//     With ARB_FIXED_PRIO_EN: order 0,0,... while port 0 keeps requesting.
//  4. Write, data stability: port 1 writes 0x0040 with wdata W, then changes req_wdata mid-BUSY.
//     -> L2_mem_write=1 and L2_mem_wdata=W throughout; resp[1] after L2_mem_resp.
//  5. Reset in BUSY, then a stray L2_mem_resp.
//     -> all outputs 0 immediately; no req_resp; next request is granted to port 0 first.
//  6. read and write set together on port 0.
//     -> L2_mem_write=1, L2_mem_read=0.

Source files
------------

// File: rtl/l2_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : l2_arbiter_rr
// Description : N-port arbiter between the L1 caches and the shared L2.
//               One requester is granted at a time; its whole-line
//               read/write is forwarded to L2 through registered outputs,
//               and the registered L2 response is returned to that
//               requester only. Port 0 is the i-cache, port 1 the d-cache.
//               Grant order is round-robin by default. Defining
//               ARB_FIXED_PRIO_EN switches to fixed priority, where the
//               lowest-index requesting port always wins.
// Revision    : 1.0 - initial N-port release
// ============================================================================
module l2_arbiter_rr #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 16,
    parameter int LINE_W    = 128
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_address,
    input  logic [NUM_PORTS-1:0]        req_read,
    input  logic [NUM_PORTS-1:0]        req_write,
    input  logic [NUM_PORTS*LINE_W-1:0] req_wdata,
    output logic [LINE_W-1:0]           req_rdata,
    output logic [NUM_PORTS-1:0]        req_resp,
    output logic [ADDR_W-1:0]           L2_mem_address,
    output logic                        L2_mem_read,
    output logic                        L2_mem_write,
    output logic [LINE_W-1:0]           L2_mem_wdata,
    input  logic                        L2_mem_resp,
    input  logic [LINE_W-1:0]           L2_mem_rdata
);

    localparam int c_IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    localparam logic [c_IDX_W-1:0] c_LAST_PORT = c_IDX_W'(NUM_PORTS - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE   = c_IDX_W'(1);

    // FSM state and latched grant
    logic [1:0]           r_state;
    logic [c_IDX_W-1:0]   r_grant;

    // Registered outputs
    logic [ADDR_W-1:0]    r_l2_addr;
    logic                 r_l2_rd;
    logic                 r_l2_wr;
    logic [LINE_W-1:0]    r_l2_wdata;
    logic [LINE_W-1:0]    r_rdata;
    logic [NUM_PORTS-1:0] r_resp;

    // Arbitration helpers
    logic [NUM_PORTS-1:0]   w_req;
    logic                   w_any_req;
    logic [c_IDX_W-1:0]     w_start;
    logic [2*NUM_PORTS-1:0] w_req_dbl;
    logic [2*NUM_PORTS-1:0] w_req_rot_full;
    logic [NUM_PORTS-1:0]   w_req_rot;
    logic [c_IDX_W-1:0]     w_pick;
    logic                   w_found;
    int                     w_sum;

    // Selected port's request fields
    logic [ADDR_W-1:0]    w_pick_addr;
    logic [LINE_W-1:0]    w_pick_wdata;
    logic                 w_pick_rd;
    logic                 w_pick_wr;
    logic [NUM_PORTS-1:0] w_onehot;

    // A port is requesting when either strobe is set
    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_req
            assign w_req[p] = req_read[p] | req_write[p];
        end
    endgenerate

    assign w_any_req = |w_req;

`ifdef ARB_FIXED_PRIO_EN
    // Fixed priority: the scan always starts at port 0, no pointer is kept
    assign w_start = '0;
`else
    logic [c_IDX_W-1:0] r_last;

    // Round-robin pointer remembers the most recently granted port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last <= c_LAST_PORT;
        end else if ((r_state == c_ST_IDLE) && w_any_req) begin
            r_last <= w_pick;
        end
    end

    // Scan starts one past the last grant, wrapping at NUM_PORTS
    assign w_start = (r_last == c_LAST_PORT) ? '0 : (r_last + c_IDX_ONE);
`endif

    // Rotate the request vector so bit 0 corresponds to the scan start port
    assign w_req_dbl      = {w_req, w_req};
    assign w_req_rot_full = w_req_dbl >> w_start;
    assign w_req_rot      = w_req_rot_full[NUM_PORTS-1:0];

    // First requesting port at or after the scan start, mapped back to a port index
    always_comb begin
        w_pick  = w_start;
        w_found = 1'b0;
        w_sum   = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!w_found && w_req_rot[i]) begin
                w_found = 1'b1;
                w_sum   = int'(w_start) + i;
                if (w_sum >= NUM_PORTS) begin
                    w_sum = w_sum - NUM_PORTS;
                end
                w_pick  = c_IDX_W'(w_sum);
            end
        end
    end

    // Select the picked port's address, data and strobes; write beats read
    always_comb begin
        w_pick_addr  = '0;
        w_pick_wdata = '0;
        w_pick_rd    = 1'b0;
        w_pick_wr    = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_pick == c_IDX_W'(p)) begin
                w_pick_addr  = req_address[p*ADDR_W +: ADDR_W];
                w_pick_wdata = req_wdata[p*LINE_W +: LINE_W];
                w_pick_wr    = req_write[p];
                w_pick_rd    = req_read[p] & ~req_write[p];
            end
        end
    end

    // One-hot view of the latched grant for the completion pulse
    always_comb begin
        w_onehot = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_onehot[p] = (r_grant == c_IDX_W'(p));
        end
    end

    // Arbitration FSM; L2 fields are frozen from grant until L2 completes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_grant    <= '0;
            r_l2_addr  <= '0;
            r_l2_rd    <= 1'b0;
            r_l2_wr    <= 1'b0;
            r_l2_wdata <= '0;
            r_rdata    <= '0;
            r_resp     <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_any_req) begin
                        r_grant    <= w_pick;
                        r_l2_addr  <= w_pick_addr;
                        r_l2_wdata <= w_pick_wdata;
                        r_l2_rd    <= w_pick_rd;
                        r_l2_wr    <= w_pick_wr;
                        r_state    <= c_ST_BUSY;
                    end
                end
                c_ST_BUSY: begin
                    if (L2_mem_resp) begin
                        r_rdata <= L2_mem_rdata;
                        r_resp  <= w_onehot;
                        r_l2_rd <= 1'b0;
                        r_l2_wr <= 1'b0;
                        r_state <= c_ST_RESP;
                    end
                end
                c_ST_RESP: begin
                    r_resp  <= '0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_resp  <= '0;
                    r_l2_rd <= 1'b0;
                    r_l2_wr <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign req_rdata      = r_rdata;
    assign req_resp       = r_resp;
    assign L2_mem_address = r_l2_addr;
    assign L2_mem_read    = r_l2_rd;
    assign L2_mem_write   = r_l2_wr;
    assign L2_mem_wdata   = r_l2_wdata;

endmodule
`default_nettype wire

// File: tb/tb_l2_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_arbiter_rr
// Description : Directed self-checking bench for l2_arbiter_rr. A 2-port
//               instance covers reset, single read, simultaneous requests,
//               write data stability, read+write on one port, stray L2
//               responses and reset mid-transaction; a 4-port instance
//               covers grant rotation.
// Revision    : 1.0 - initial bench
// ============================================================================
module tb_l2_arbiter_rr;

    logic clk;
    logic rst;

    // 2-port instance signals
    logic [31:0]  a_addr;
    logic [1:0]   a_read;
    logic [1:0]   a_write;
    logic [255:0] a_wdata;
    logic [127:0] a_rdata;
    logic [1:0]   a_resp;
    logic [15:0]  a_l2_addr;
    logic         a_l2_rd;
    logic         a_l2_wr;
    logic [127:0] a_l2_wdata;
    logic         a_l2_resp;
    logic [127:0] a_l2_rdata;

    // 4-port instance signals
    logic [63:0]  b_addr;
    logic [3:0]   b_read;
    logic [3:0]   b_write;
    logic [511:0] b_wdata;
    logic [127:0] b_rdata;
    logic [3:0]   b_resp;
    logic [15:0]  b_l2_addr;
    logic         b_l2_rd;
    logic         b_l2_wr;
    logic [127:0] b_l2_wdata;
    logic         b_l2_resp;
    logic [127:0] b_l2_rdata;

    int total;
    int bad;

    l2_arbiter_rr #(.NUM_PORTS(2), .ADDR_W(16), .LINE_W(128)) u_dut2 (
        .clk            (clk),
        .reset          (rst),
        .req_address    (a_addr),
        .req_read       (a_read),
        .req_write      (a_write),
        .req_wdata      (a_wdata),
        .req_rdata      (a_rdata),
        .req_resp       (a_resp),
        .L2_mem_address (a_l2_addr),
        .L2_mem_read    (a_l2_rd),
        .L2_mem_write   (a_l2_wr),
        .L2_mem_wdata   (a_l2_wdata),
        .L2_mem_resp    (a_l2_resp),
        .L2_mem_rdata   (a_l2_rdata)
    );

    l2_arbiter_rr #(.NUM_PORTS(4), .ADDR_W(16), .LINE_W(128)) u_dut4 (
        .clk            (clk),
        .reset          (rst),
        .req_address    (b_addr),
        .req_read       (b_read),
        .req_write      (b_write),
        .req_wdata      (b_wdata),
        .req_rdata      (b_rdata),
        .req_resp       (b_resp),
        .L2_mem_address (b_l2_addr),
        .L2_mem_read    (b_l2_rd),
        .L2_mem_write   (b_l2_wr),
        .L2_mem_wdata   (b_l2_wdata),
        .L2_mem_resp    (b_l2_resp),
        .L2_mem_rdata   (b_l2_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Overall time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    localparam logic [127:0] c_A5 = {16{8'hA5}};
    localparam logic [127:0] c_D0 = {16{8'hD0}};
    localparam logic [127:0] c_D1 = {16{8'hD1}};
    localparam logic [127:0] c_W  = {4{32'h1111_2222}};
    localparam logic [127:0] c_W2 = {4{32'h3333_4444}};
    localparam logic [127:0] c_C3 = {16{8'hC3}};
    localparam logic [127:0] c_E7 = {16{8'hE7}};

    initial begin
        int exp_port;
        bit seen;
        logic [3:0] exp_oh;

        total = 0;
        bad   = 0;
        rst        = 1'b1;
        a_addr     = '0; a_read = '0; a_write = '0; a_wdata = '0;
        a_l2_resp  = 1'b0; a_l2_rdata = '0;
        b_addr     = '0; b_read = '0; b_write = '0; b_wdata = '0;
        b_l2_resp  = 1'b0; b_l2_rdata = '0;

        // ---- Reset values ----
        repeat (2) @(posedge clk);
        #1;
        check("rst_resp",  128'(a_resp), 128'(2'b00));
        check("rst_rdata", a_rdata, 128'h0);
        check("rst_l2",    128'({a_l2_addr, a_l2_rd, a_l2_wr}), 128'h0);
        check("rst_wdata", a_l2_wdata, 128'h0);
        rst = 1'b0;

        // ---- Test 1: port 1 single read, L2 answers 3 cycles later ----
        a_addr[31:16] = 16'h1230;
        a_read        = 2'b10;
        tick();
        check("t1_rd",   128'({a_l2_rd, a_l2_wr}), 128'(2'b10));
        check("t1_addr", 128'(a_l2_addr), 128'h1230);
        tick();
        tick();
        check("t1_hold_rd",   128'(a_l2_rd), 128'(1'b1));
        check("t1_hold_resp", 128'(a_resp), 128'(2'b00));
        a_l2_resp = 1'b1; a_l2_rdata = c_A5;
        tick();
        a_l2_resp = 1'b0; a_l2_rdata = '0;
        check("t1_resp",  128'(a_resp), 128'(2'b10));
        check("t1_rdata", a_rdata, c_A5);
        check("t1_rd_clr", 128'(a_l2_rd), 128'(1'b0));
        a_read = 2'b00;
        tick();
        check("t1_resp_pulse", 128'(a_resp), 128'(2'b00));
        check("t1_rdata_hold", a_rdata, c_A5);

        // ---- Test 2: both ports read, port 0 first then port 1 ----
        a_addr = {16'h0200, 16'h0100};
        a_read = 2'b11;
        tick();
        check("t2_first_addr", 128'(a_l2_addr), 128'h0100);
        check("t2_first_rd",   128'(a_l2_rd), 128'(1'b1));
        a_l2_resp = 1'b1; a_l2_rdata = c_D0;
        tick();
        a_l2_resp = 1'b0;
        check("t2_first_resp",  128'(a_resp), 128'(2'b01));
        check("t2_first_rdata", a_rdata, c_D0);
        check("t2_gap_rd0",     128'(a_l2_rd), 128'(1'b0));
        a_read = 2'b10;
        tick();
        check("t2_gap_rd1", 128'(a_l2_rd), 128'(1'b0));
        tick();
        check("t2_second_addr", 128'(a_l2_addr), 128'h0200);
        check("t2_second_rd",   128'(a_l2_rd), 128'(1'b1));
        a_l2_resp = 1'b1; a_l2_rdata = c_D1;
        tick();
        a_l2_resp = 1'b0;
        check("t2_second_resp",  128'(a_resp), 128'(2'b10));
        check("t2_second_rdata", a_rdata, c_D1);
        a_read = 2'b00;
        tick();

        // ---- Test 4: port 1 write, wdata changes mid-BUSY ----
        a_addr[31:16]    = 16'h0040;
        a_wdata[255:128] = c_W;
        a_write          = 2'b10;
        tick();
        check("t4_strobes", 128'({a_l2_rd, a_l2_wr}), 128'(2'b01));
        check("t4_addr",    128'(a_l2_addr), 128'h0040);
        check("t4_wdata",   a_l2_wdata, c_W);
        a_wdata[255:128] = c_E7;
        a_addr[31:16]    = 16'h7777;
        tick();
        check("t4_wdata_stable", a_l2_wdata, c_W);
        check("t4_addr_stable",  128'(a_l2_addr), 128'h0040);
        check("t4_wr_stable",    128'(a_l2_wr), 128'(1'b1));
        a_l2_resp = 1'b1; a_l2_rdata = c_C3;
        tick();
        a_l2_resp = 1'b0;
        check("t4_resp",  128'(a_resp), 128'(2'b10));
        check("t4_rdata", a_rdata, c_C3);
        check("t4_wr_clr", 128'(a_l2_wr), 128'(1'b0));
        a_write = 2'b00;
        tick();

        // ---- Test 6: read and write together on port 0 ----
        a_addr[15:0]   = 16'h0300;
        a_wdata[127:0] = c_W2;
        a_read         = 2'b01;
        a_write        = 2'b01;
        tick();
        check("t6_strobes", 128'({a_l2_rd, a_l2_wr}), 128'(2'b01));
        check("t6_wdata",   a_l2_wdata, c_W2);
        a_l2_resp = 1'b1; a_l2_rdata = c_D0;
        tick();
        a_l2_resp = 1'b0;
        check("t6_resp", 128'(a_resp), 128'(2'b01));
        a_read = 2'b00; a_write = 2'b00;
        tick();

        // ---- Stray L2 response while IDLE is ignored ----
        a_l2_resp = 1'b1; a_l2_rdata = c_E7;
        tick();
        a_l2_resp = 1'b0;
        check("idle_stray_resp",  128'(a_resp), 128'(2'b00));
        check("idle_stray_rdata", a_rdata, c_D0);
        check("idle_stray_rd",    128'(a_l2_rd), 128'(1'b0));

        // ---- Test 5: reset in BUSY with port 0 granted, then stray resp ----
        a_addr[15:0] = 16'h0500;
        a_read       = 2'b01;
        tick();
        check("t5_busy_rd", 128'(a_l2_rd), 128'(1'b1));
        rst    = 1'b1;
        a_read = 2'b00;
        #1;
        check("t5_async_l2",    128'({a_l2_addr, a_l2_rd, a_l2_wr}), 128'h0);
        check("t5_async_rdata", a_rdata, 128'h0);
        check("t5_async_resp",  128'(a_resp), 128'(2'b00));
        #1;
        rst = 1'b0;
        a_l2_resp = 1'b1; a_l2_rdata = c_A5;
        tick();
        a_l2_resp = 1'b0;
        check("t5_stray_resp",  128'(a_resp), 128'(2'b00));
        check("t5_stray_rdata", a_rdata, 128'h0);
        a_addr = {16'h0600, 16'h0500};
        a_read = 2'b11;
        tick();
        check("t5_regrant_addr", 128'(a_l2_addr), 128'h0500);
        a_l2_resp = 1'b1;
        tick();
        a_l2_resp = 1'b0;
        check("t5_regrant_resp", 128'(a_resp), 128'(2'b01));
        a_read = 2'b00;
        tick();

        // ---- Test 3: 4-port rotation, all ports requesting continuously ----
        b_addr = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
        b_read = 4'b1111;
        for (int t = 0; t < 8; t++) begin
`ifdef ARB_FIXED_PRIO_EN
            exp_port = 0;
`else
            exp_port = t % 4;
`endif
            exp_oh = 4'b0001 << exp_port;
            seen = 1'b0;
            for (int w = 0; w < 10; w++) begin
                if (!seen) begin
                    tick();
                    if (b_l2_rd) seen = 1'b1;
                end
            end
            total++;
            assert (seen) else begin
                bad++;
                $error("FAIL t3_grant_timeout txn %0d: observed=no_read expected=read", t);
            end
            check($sformatf("t3_addr_txn%0d", t), 128'(b_l2_addr), 128'(16'h1000 + exp_port));
            b_l2_resp = 1'b1; b_l2_rdata = 128'(t + 1);
            tick();
            b_l2_resp = 1'b0;
            check($sformatf("t3_resp_txn%0d", t), 128'(b_resp), 128'(exp_oh));
            check($sformatf("t3_rdata_txn%0d", t), b_rdata, 128'(t + 1));
        end
        b_read = 4'b0000;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
